// File: rtl/alarm_arm_ctrl.sv
// alarm_arm_ctrl: debounced multi-sensor arming controller with exit delay, wrong-code lockout and sticky trip record
module alarm_arm_ctrl #(
    parameter int N_SENSE = 4,
    parameter int CODE_W = 10,
    parameter logic [CODE_W-1:0] SHUTDOWN_CODE = 'h112,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int ARM_DELAY_CYC = 250000000,
    parameter int MAX_TRIES = 3,
    parameter int LOCKOUT_CYC = 500000000,
    localparam int TW = $clog2(MAX_TRIES + 1)
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [N_SENSE-1:0] iSENSE,
    input  logic [N_SENSE-1:0] iSENSE_MASK,
    input  logic [CODE_W-1:0]  iCODE,
    input  logic               iCODE_STB,
    output logic               oVIDEO_ON,
    output logic               oARMED,
    output logic [N_SENSE-1:0] oTRIG_CH,
    output logic [TW-1:0]      oTRIES,
    output logic               oLOCKED,
    output logic [2:0]         oSTATE
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int CMAX = ARM_DELAY_CYC > LOCKOUT_CYC ? ARM_DELAY_CYC : LOCKOUT_CYC;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        ARMING   = 3'd1,
        ARMED    = 3'd2,
        ALARM    = 3'd3,
        LOCKOUT  = 3'd4
    } state_t;

    state_t state, state_n;
    logic [N_SENSE-1:0] sync1, sync2, deb, deb_d, ev, trig_n;
    logic [DW-1:0] db_cnt [N_SENSE];
    logic stb_d, sub, match;
    logic [CW-1:0] cnt, cnt_n;
    logic [TW-1:0] tries_n, tries_up;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            ev    <= '0;
            stb_d <= 1'b0;
            for (int i = 0; i < N_SENSE; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= iSENSE;
            sync2 <= sync1;
            deb_d <= deb;
            ev    <= (deb ^ deb_d) & ~iSENSE_MASK;
            stb_d <= iCODE_STB;
            for (int i = 0; i < N_SENSE; i++) begin
                db_cnt[i] <= (sync2[i] != deb[i] && db_cnt[i] != DW'(DEBOUNCE_CYC - 1)) ? db_cnt[i] + 1'b1 : '0;
                if (sync2[i] != deb[i] && db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) deb[i] <= sync2[i];
            end
        end
    end

    // one down-counter serves both the exit delay and the lockout, which never overlap
    always_comb begin
        sub      = iCODE_STB & ~stb_d;
        match    = iCODE == SHUTDOWN_CODE;
        tries_up = oTRIES + 1'b1;
        state_n  = state;
        cnt_n    = cnt != '0 ? cnt - 1'b1 : cnt;
        tries_n  = oTRIES;
        trig_n   = oTRIG_CH;
        case (state)
            DISARMED: begin
                tries_n = '0;
                trig_n  = '0;
                if (sub && iCODE == '0) begin
                    state_n = ARMING;
                    cnt_n   = CW'(ARM_DELAY_CYC);
                end
            end
            ARMING, ARMED, ALARM: begin
                if (state != ARMING) trig_n = oTRIG_CH | ev;
                if (state == ARMING && cnt <= CW'(1)) state_n = ARMED;
                if (state == ARMED && |ev) state_n = ALARM;
                if (sub && match) begin
                    state_n = DISARMED;
                    tries_n = '0;
                    trig_n  = '0;
                end else if (sub) begin
                    tries_n = tries_up;
                    if (tries_up == TW'(MAX_TRIES)) begin
                        state_n = LOCKOUT;
                        cnt_n   = CW'(LOCKOUT_CYC);
                    end
                end
            end
            LOCKOUT: begin
                trig_n = oTRIG_CH | ev;
                if (cnt <= CW'(1)) begin
                    state_n = ALARM;
                    tries_n = '0;
                end
            end
            default: begin
                state_n = DISARMED;
                tries_n = '0;
                trig_n  = '0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= DISARMED;
            cnt      <= '0;
            oTRIES   <= '0;
            oTRIG_CH <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            oTRIES   <= tries_n;
            oTRIG_CH <= trig_n;
        end
    end

    assign oSTATE    = state;
    assign oVIDEO_ON = state == ALARM || state == LOCKOUT;
    assign oARMED    = state == ARMING || state == ARMED;
    assign oLOCKED   = state == LOCKOUT;
endmodule

// File: doc/alarm_arm_ctrl.md
# alarm_arm_ctrl

- Parametrised arming/surveillance controller.
- Watches N debounced sensor channels and a switch-entered passcode, and drives the video-enable that gates the TV decoder, I2C config and SDRAM frame-buffer reset chain.
- Adds the following:
  - multi-channel sensors with per-channel masking;
  - an exit (arming) delay;
  - failed-code counting with a timed lockout;
  - a sticky record of which channel tripped.

## Interface
Parameters:
- N_SENSE, 4: number of sensor channels.
- CODE_W, 10: passcode width.
- SHUTDOWN_CODE, 10'h112: disarm code.
- DEBOUNCE_CYC, 50000: consecutive stable cycles needed to accept a sensor level. Must be ≥1.
- ARM_DELAY_CYC, 250000000: exit delay between arm request and ARMED. Must be ≥ DEBOUNCE_CYC+3.
- MAX_TRIES, 3: wrong codes tolerated before lockout. Must be ≥1.
- LOCKOUT_CYC, 500000000: lockout duration.

Ports:
- iCLK, in, 1: system clock. One clock only; all logic on the rising edge.
- iRST_N, in, 1: reset, asynchronous, active-low.
- iSENSE, in, N_SENSE: raw asynchronous sensor levels.
- iSENSE_MASK, in, N_SENSE: 1 = channel ignored. Synchronous, static while ARMED.
- iCODE, in, CODE_W: entered code. Synchronous, stable while iCODE_STB is high.
- iCODE_STB, in, 1: submit request, synchronous level. Acts on its rising edge.
- oVIDEO_ON, out, 1: video-path enable.
- oARMED, out, 1: high in ARMING and ARMED.
- oTRIG_CH, out, N_SENSE: sticky channels that caused or joined the alarm.
- oTRIES, out, ceil(log2(MAX_TRIES+1)): wrong-code count.
- oLOCKED, out, 1: high in LOCKOUT.
- oSTATE, out, 3: encoded state.

## Operation
Sensor path, per channel:
- A 2-flop synchroniser feeds the debouncer.
- The debounce counter counts while the synchronised value differs from the debounced value. It clears when they are equal.
- When the count has run DEBOUNCE_CYC cycles, the debounced value takes the synchronised value.
- An event is any change, either polarity, of a debounced unmasked channel. It is registered one cycle.

Submit:
- A submit is iCODE_STB high with its previous-cycle value low.
- A held strobe acts once.
- match = (iCODE == SHUTDOWN_CODE).

States (oSTATE encoding):

DISARMED (0):
- Submit with iCODE == 0 → ARMING and load the delay counter.
- Any other submit is ignored.
- oTRIES = 0 and oTRIG_CH = 0 while in this state.

ARMING (1):
- The delay counter counts down ARM_DELAY_CYC cycles, then → ARMED.
- A match submit → DISARMED.
- Sensor events are ignored.

ARMED (2):
- Any event → ALARM, and oTRIG_CH |= event vector.
- A match submit → DISARMED.

ALARM (3):
- Further events OR into oTRIG_CH.
- A match submit → DISARMED.

LOCKOUT (4):
- All submits are ignored.
- Events still OR into oTRIG_CH.
- After LOCKOUT_CYC cycles → ALARM, and oTRIES clears.

Wrong codes:
- In ARMING, ARMED or ALARM, a non-matching submit increments oTRIES.
- When the increment reaches MAX_TRIES → LOCKOUT, from any of those three states.

Outputs:
- oVIDEO_ON = 1 in ALARM and LOCKOUT.
- oLOCKED = 1 in LOCKOUT.
- All outputs are registered or decoded from registered state. No input-to-output combinational path.
- Encodings 5–7 are illegal and recover to DISARMED on the next edge.

## Timing
Reset:
- Reset asserted → DISARMED; all outputs 0; counters, synchronisers and debounced values 0; previous strobe 0.
- Reset mid-operation aborts any delay, alarm or lockout immediately.

Sensor latency:
- A raw change sampled at edge k makes the debounced value change at edge k+1+DEBOUNCE_CYC.
- The registered event appears at edge k+2+DEBOUNCE_CYC.
- The state and oVIDEO_ON update at edge k+3+DEBOUNCE_CYC.
- A glitch shorter than DEBOUNCE_CYC synchronised cycles produces no event.

Submit latency:
- A strobe rising before edge j is seen as high at edge j. The state, oTRIES and oTRIG_CH update at edge j.

Simultaneous events:
- A match submit and an event in the same cycle in ARMED → DISARMED. Disarm wins.
- A wrong submit and an event in the same cycle in ARMED: go to ALARM or LOCKOUT per the tries count. oTRIG_CH still records the event.

Counter boundaries:
- The ARMING and LOCKOUT counters saturate at 0.
- oTRIES never exceeds MAX_TRIES.

## Test plan
All scenarios use DEBOUNCE_CYC=4, ARM_DELAY_CYC=20, MAX_TRIES=3, LOCKOUT_CYC=30.

1. Arm and alarm:
   - Stimulus: from reset, submit code 0; wait 20 cycles; toggle iSENSE[2].
   - Required: oARMED goes high 1 cycle after the submit. oSTATE=2 after 20 cycles. oVIDEO_ON and oSTATE=3 arrive 7 edges after the toggle. oTRIG_CH=4'b0100.
2. Glitch and mask:
   - Stimulus: in ARMED, a 3-cycle pulse on iSENSE[0], then a long change on masked channel 1.
   - Required: oSTATE stays 2 and oVIDEO_ON stays 0.
3. Disarm:
   - Stimulus: in ALARM, submit 10'h112.
   - Required: next edge oSTATE=0, oVIDEO_ON=0, oTRIG_CH=0, oTRIES=0.
4. Lockout:
   - Stimulus: three submits of 10'h001 in ARMED, then a submit of 10'h112 during lockout.
   - Required: oTRIES goes 1,2,3. oLOCKED and oVIDEO_ON are high. The 10'h112 submit is ignored. After 30 cycles oSTATE=3, oTRIES=0, oLOCKED=0.
5. Race:
   - Stimulus: a match submit on the same edge as a debounced event in ARMED.
   - Required: oSTATE=0 and oVIDEO_ON never asserts.
6. Reset mid-ARMING:
   - Stimulus: pulse iRST_N low for half a cycle at cycle 10 of ARMING.
   - Required: all outputs 0 immediately. A later submit of 0 restarts a full 20-cycle delay. A held iCODE_STB produces no second arm.
